// File: rtl/host_sequencer.sv
// Host-side run sequencer: clears data memory, loads operand bytes, launches the
// core via start, waits for halt (or a timeout) and reads result bytes back.
module host_sequencer #(
  parameter int          NUM_LOAD  = 3,
  parameter logic [7:0]  LOAD_BASE = 8'd0,
  parameter int          NUM_READ  = 3,
  parameter logic [7:0]  READ_BASE = 8'd4,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [7:0]  cfg_data,
  input  logic        go,
  input  logic        halt,
  output logic        start,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result,
  output logic [15:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_LAUNCH, S_RUN, S_READ, S_DONE
  } state_t;

  localparam logic [2:0] LP_LOAD_LAST = 3'(NUM_LOAD - 1);
  localparam logic [2:0] LP_READ_LAST = 3'(NUM_READ - 1);
  localparam logic [2:0] LP_READ_N    = 3'(NUM_READ);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_shadow [4];
  logic        r_start;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;
  logic [31:0] r_result;
  logic [15:0] r_run;

  logic [1:0]  w_idx_inc;
  logic [1:0]  w_cap_idx;
  logic [15:0] w_run_next;

  assign w_idx_inc  = r_idx[1:0] + 2'd1;
  // READ cycle j captures the byte addressed in cycle j-1
  assign w_cap_idx  = r_idx[1:0] - 2'd1;
  assign w_run_next = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;

  assign start      = r_start;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign result     = r_result;
  assign run_cycles = r_run;

  // Sequencer FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_start   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= 8'd0;
      r_wdata   <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= 32'd0;
      r_run     <= 16'd0;
      for (int k = 0; k < 4; k++) r_shadow[k] <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) r_shadow[cfg_idx] <= cfg_data;
          if (go) begin
            r_state   <= S_CLEAR;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
            r_result  <= 32'd0;
            r_run     <= 16'd0;
            r_we      <= 1'b1;
            r_addr    <= 8'd0;
            r_wdata   <= 8'd0;
          end
        end
        S_CLEAR: begin
          if (r_addr == 8'hFF) begin
            r_state <= S_LOAD;
            r_idx   <= 3'd0;
            r_addr  <= LOAD_BASE;
            r_wdata <= r_shadow[0];
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        S_LOAD: begin
          if (r_idx == LP_LOAD_LAST) begin
            r_state <= S_LAUNCH;
            r_we    <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_addr  <= LOAD_BASE + {5'd0, r_idx + 3'd1};
            r_wdata <= r_shadow[w_idx_inc];
          end
        end
        S_LAUNCH: begin
          r_state <= S_RUN;
          r_start <= 1'b0;
        end
        S_RUN: begin
          r_run <= w_run_next;
          if (halt) begin
            r_state <= S_READ;
            r_start <= 1'b1;
            r_idx   <= 3'd0;
            r_addr  <= READ_BASE;
          end else if (w_run_next >= TIMEOUT) begin
            r_state   <= S_IDLE;
            r_start   <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        S_READ: begin
          if (r_idx != 3'd0) r_result[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
          if (r_idx == LP_READ_N) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_addr  <= 8'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
            if (r_idx != LP_READ_LAST) r_addr <= READ_BASE + {5'd0, r_idx + 3'd1};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= 8'd0;
          r_wdata <= 8'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_sequencer.sv
// Scoreboard bench for host_sequencer: two instances (defaults, and a short
// timeout with a wrapping operand base) each with a synchronous-read memory model.
module tb_host_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] res;
    logic [15:0] runc;
    int          dcyc;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // instance A signals (default parameters)
  logic a_cfg_we, a_go, a_halt;
  logic [1:0] a_cfg_idx;
  logic [7:0] a_cfg_data;
  logic a_start, a_we, a_busy, a_done, a_to;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic [31:0] a_res;
  logic [15:0] a_runc;

  // instance B signals (TIMEOUT=20, LOAD_BASE=FE)
  logic b_cfg_we, b_go, b_halt;
  logic [1:0] b_cfg_idx;
  logic [7:0] b_cfg_data;
  logic b_start, b_we, b_busy, b_done, b_to;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic [31:0] b_res;
  logic [15:0] b_runc;

  host_sequencer dut_a (
    .CLK(clk), .RESET_N(rst_n), .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_data(a_cfg_data),
    .go(a_go), .halt(a_halt), .start(a_start), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .busy(a_busy), .done(a_done),
    .timeout(a_to), .result(a_res), .run_cycles(a_runc)
  );

  host_sequencer #(.LOAD_BASE(8'hFE), .TIMEOUT(16'd20)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_data(b_cfg_data),
    .go(b_go), .halt(b_halt), .start(b_start), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .busy(b_busy), .done(b_done),
    .timeout(b_to), .result(b_res), .run_cycles(b_runc)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [255:0] a_zero = 256'd0;
  logic a_zero_clr = 1'b0;
  logic a_pre_en = 1'b0;
  logic b_pre_en = 1'b0;
  logic [7:0] a_pre [3];
  logic [7:0] b_pre [3];
  logic b_rd_seen = 1'b0;

  // memory model A: synchronous read, tracks addresses written with zero
  always @(posedge clk) begin
    if (a_zero_clr) a_zero <= 256'd0;
    if (a_we) begin
      mem_a[a_addr] <= a_wdata;
      if (a_wdata == 8'd0 && !a_zero_clr) a_zero[a_addr] <= 1'b1;
    end
    if (a_pre_en) begin
      mem_a[8'd4] <= a_pre[0];
      mem_a[8'd5] <= a_pre[1];
      mem_a[8'd6] <= a_pre[2];
    end
    a_rdata <= mem_a[a_addr];
  end

  // memory model B
  always @(posedge clk) begin
    if (b_we) mem_b[b_addr] <= b_wdata;
    if (b_pre_en) begin
      mem_b[8'd4] <= b_pre[0];
      mem_b[8'd5] <= b_pre[1];
      mem_b[8'd6] <= b_pre[2];
    end
    b_rdata <= mem_b[b_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // monitor A: every done pulse must match the oldest expected run
  always @(negedge clk) begin
    exp_t e;
    if (a_done) begin
      if (q_a.size() == 0) chk("a_done_unexpected", 32'(a_done), 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_result", a_res, e.res);
        chk("a_run_cycles", 32'(a_runc), 32'(e.runc));
        chk("a_done_cycle", 32'(cyc), 32'(e.dcyc));
        chk("a_timeout_at_done", 32'(a_to), 32'd0);
      end
    end
  end

  // monitor B, plus detection of any READ-address cycle
  always @(negedge clk) begin
    exp_t e;
    if (b_busy && !b_we && b_addr == 8'd4) b_rd_seen <= 1'b1;
    if (b_done) begin
      if (q_b.size() == 0) chk("b_done_unexpected", 32'(b_done), 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_result", b_res, e.res);
        chk("b_run_cycles", 32'(b_runc), 32'(e.runc));
        chk("b_done_cycle", 32'(cyc), 32'(e.dcyc));
      end
    end
  end

  task automatic cfg(input bit sel, input logic [1:0] idx, input logic [7:0] d);
    if (sel) begin b_cfg_we = 1'b1; b_cfg_idx = idx; b_cfg_data = d; end
    else begin a_cfg_we = 1'b1; a_cfg_idx = idx; a_cfg_data = d; end
    @(negedge clk);
    a_cfg_we = 1'b0;
    b_cfg_we = 1'b0;
  endtask

  // go sampled at the next edge (edge 0); returns in cycle 1
  task automatic do_go(input bit sel, output int c0);
    c0 = cyc;
    if (sel) b_go = 1'b1; else a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    b_go = 1'b0;
  endtask

  task automatic wait_start_fall(input bit sel);
    for (int g = 0; g < 400 && (sel ? b_start : a_start); g++) @(negedge clk);
    chk(sel ? "b_start_fall" : "a_start_fall", 32'(sel ? b_start : a_start), 32'd0);
  endtask

  task automatic wait_idle(input bit sel);
    for (int g = 0; g < 400 && (sel ? b_busy : a_busy); g++) @(negedge clk);
    chk(sel ? "b_idle" : "a_idle", 32'(sel ? b_busy : a_busy), 32'd0);
  endtask

  // wait n cycles, raise halt for one cycle, check start and READ addresses
  task automatic halt_run(input bit sel, input int n, input logic [31:0] res, input logic [15:0] rc);
    exp_t e;
    repeat (n) @(negedge clk);
    e.res = res; e.runc = rc; e.dcyc = cyc + 5;
    if (sel) begin q_b.push_back(e); b_halt = 1'b1; end
    else begin q_a.push_back(e); a_halt = 1'b1; end
    @(negedge clk);
    a_halt = 1'b0;
    b_halt = 1'b0;
    chk("start_after_halt", 32'(sel ? b_start : a_start), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("read_addr", 32'(sel ? b_addr : a_addr), 32'(8'd4 + 8'(k)));
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    rst_n = 1'b0;
    {a_cfg_we, a_go, a_halt, b_cfg_we, b_go, b_halt} = 6'd0;
    {a_cfg_idx, b_cfg_idx} = 4'd0;
    {a_cfg_data, b_cfg_data} = 16'd0;
    a_pre[0] = 8'h12; a_pre[1] = 8'h34; a_pre[2] = 8'h56;
    b_pre[0] = 8'hAB; b_pre[1] = 8'hCD; b_pre[2] = 8'hEF;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(a_start), 32'd1);
    chk("rst_ctl", 32'({a_we, a_busy, a_done, a_to}), 32'd0);
    chk("rst_addr_wdata", 32'({a_addr, a_wdata}), 32'd0);
    chk("rst_result", a_res, 32'd0);
    chk("rst_run_cycles", 32'(a_runc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted in the middle of CLEAR
    cfg(1'b0, 2'd0, 8'h00); cfg(1'b0, 2'd1, 8'h24); cfg(1'b0, 2'd2, 8'h01);
    do_go(1'b0, c0);
    for (int g = 0; g < 300 && a_addr != 8'd100; g++) @(negedge clk);
    chk("clear_reach_100", 32'(a_addr), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_start", 32'(a_start), 32'd1);
    chk("async_rst_ctl", 32'({a_we, a_busy, a_addr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // run 1: operands 00/24/01, results preset, halt on the 40th RUN cycle
    cfg(1'b0, 2'd0, 8'h00); cfg(1'b0, 2'd1, 8'h24); cfg(1'b0, 2'd2, 8'h01);
    a_zero_clr = 1'b1;
    @(negedge clk);
    a_zero_clr = 1'b0;
    do_go(1'b0, c0);
    chk("restart_clear_addr0", 32'({a_busy, a_we, a_addr, a_wdata}), 32'({1'b1, 1'b1, 8'd0, 8'd0}));
    wait_start_fall(1'b0);
    chk("a_start_fall_cycle", 32'(cyc - c0), 32'd261);
    a_pre_en = 1'b1;
    @(negedge clk);
    a_pre_en = 1'b0;
    halt_run(1'b0, 40 - 2, 32'h00563412, 16'd40);
    wait_idle(1'b0);
    chk("clear_all_256", 32'(&a_zero), 32'd1);
    chk("load_bytes", 32'({mem_a[0], mem_a[1], mem_a[2]}), 32'h00002401);

    // run 2: halt held high from before go; exits after exactly one RUN cycle
    a_halt = 1'b1;
    do_go(1'b0, c0);
    q_a.push_back('{res: 32'd0, runc: 16'd1, dcyc: c0 + 266});
    wait_idle(1'b0);
    a_halt = 1'b0;

    // run 3: go and cfg_we pulsed during RUN are ignored
    do_go(1'b0, c0);
    wait_start_fall(1'b0);
    a_go = 1'b1; a_cfg_we = 1'b1; a_cfg_idx = 2'd1; a_cfg_data = 8'hFF;
    @(negedge clk);
    a_go = 1'b0; a_cfg_we = 1'b0;
    chk("no_restart_in_run", 32'(a_start), 32'd0);
    halt_run(1'b0, 8, 32'd0, 16'd10);
    wait_idle(1'b0);

    // run 4: original operands still loaded
    do_go(1'b0, c0);
    wait_start_fall(1'b0);
    chk("shadow_kept", 32'(mem_a[1]), 32'h24);
    halt_run(1'b0, 4, 32'd0, 16'd5);
    wait_idle(1'b0);

    // instance B: timeout after 20 RUN cycles, operands wrap FE/FF/00
    cfg(1'b1, 2'd0, 8'h11); cfg(1'b1, 2'd1, 8'h22); cfg(1'b1, 2'd2, 8'h33);
    do_go(1'b1, c0);
    wait_start_fall(1'b1);
    n = 0;
    while (!b_start && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b_timeout_run_len", 32'(n), 32'd20);
    chk("b_timeout_flag", 32'({b_to, b_start, b_busy}), 32'b110);
    chk("b_timeout_run_cycles", 32'(b_runc), 32'd20);
    repeat (5) @(negedge clk);
    chk("b_timeout_sticky", 32'(b_to), 32'd1);
    chk("b_no_read_addr", 32'(b_rd_seen), 32'd0);
    chk("b_load_wrap", 32'({mem_b[8'hFE], mem_b[8'hFF], mem_b[8'h00]}), 32'h00112233);

    // second go clears timeout and completes normally
    do_go(1'b1, c0);
    chk("b_timeout_cleared", 32'(b_to), 32'd0);
    wait_start_fall(1'b1);
    b_pre_en = 1'b1;
    @(negedge clk);
    b_pre_en = 1'b0;
    halt_run(1'b1, 7 - 2, 32'h00EFCDAB, 16'd7);
    wait_idle(1'b1);
    chk("b_timeout_after_ok", 32'(b_to), 32'd0);

    repeat (3) @(negedge clk);
    chk("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
    chk("b_scoreboard_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
